// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and inter-stage control bundle.
// ALU control codes, ALUOp encodings and R-type funct values.
package mips_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } ex_ctrl_t;

endpackage

// File: rtl/alu_control_dec.sv
// ALUOp + funct to 4-bit ALU control decoder (pure combinational).
// Unknown R-type funct falls back to add and raises illegal.
module alu_control_dec
   import mips_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] ctrl_o,
   output logic       illegal_o
);

   always_comb begin
      ctrl_o    = ALU_ADD;
      illegal_o = 1'b0;
      unique case (alu_op_i)
         ALUOP_ADD: ctrl_o = ALU_ADD;
         ALUOP_SUB: ctrl_o = ALU_SUB;
         ALUOP_OR:  ctrl_o = ALU_OR;
         ALUOP_RTYPE: begin
            case (funct_i)
               FN_ADD:  ctrl_o = ALU_ADD;
               FN_SUB:  ctrl_o = ALU_SUB;
               FN_AND:  ctrl_o = ALU_AND;
               FN_OR:   ctrl_o = ALU_OR;
               FN_SLT:  ctrl_o = ALU_SLT;
               default: illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and load-use detect.
// Define ID_EX_FORWARD_EN to forward MEM/WB results onto the operands.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic [1:0]        id_alu_op_i,
   input  logic [5:0]        id_funct_i,
   input  logic              id_alu_src_i,
   input  logic              id_reg_dst_i,
   input  logic              id_reg_write_i,
   input  logic              id_mem_read_i,
   input  logic              id_mem_write_i,
   input  logic              id_mem_to_reg_i,
   input  logic              mem_reg_write_i,
   input  logic [REG_AW-1:0] mem_wr_reg_i,
   input  logic [DATA_W-1:0] mem_result_i,
   input  logic              wb_reg_write_i,
   input  logic [REG_AW-1:0] wb_wr_reg_i,
   input  logic [DATA_W-1:0] wb_result_i,
   output logic              ex_valid_o,
   output logic [DATA_W-1:0] ex_a_o,
   output logic [DATA_W-1:0] ex_b_o,
   output logic [3:0]        ex_alu_control_o,
   output logic [DATA_W-1:0] ex_store_data_o,
   output logic [REG_AW-1:0] ex_wr_reg_o,
   output logic              ex_reg_write_o,
   output logic              ex_mem_read_o,
   output logic              ex_mem_write_o,
   output logic              ex_mem_to_reg_o,
   output logic              ex_illegal_o,
   output logic              hazard_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [REG_AW-1:0] rs_q, rs_d;
   logic [REG_AW-1:0] rt_q, rt_d;
   logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
   logic              alu_src_q, alu_src_d;
   logic [3:0]        alu_ctrl_q, alu_ctrl_d;
   logic              illegal_q, illegal_d;
   ex_ctrl_t          ctl_q, ctl_d;

   logic [3:0]        dec_ctrl;
   logic              dec_illegal;
   logic [DATA_W-1:0] fwd_rs, fwd_rt;

   alu_control_dec u_dec (
      .alu_op_i  (id_alu_op_i),
      .funct_i   (id_funct_i),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      valid_d    = valid_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      wr_reg_d   = wr_reg_q;
      alu_src_d  = alu_src_q;
      alu_ctrl_d = alu_ctrl_q;
      illegal_d  = illegal_q;
      ctl_d      = ctl_q;
      // flush beats stall; an idle ID also yields a bubble
      if (flush_i || (!stall_i && !id_valid_i)) begin
         valid_d    = 1'b0;
         rs_data_d  = '0;
         rt_data_d  = '0;
         imm_d      = '0;
         rs_d       = '0;
         rt_d       = '0;
         wr_reg_d   = '0;
         alu_src_d  = 1'b0;
         alu_ctrl_d = '0;
         illegal_d  = 1'b0;
         ctl_d      = '0;
      end else if (!stall_i) begin
         valid_d    = 1'b1;
         rs_data_d  = id_rs_data_i;
         rt_data_d  = id_rt_data_i;
         imm_d      = id_imm_i;
         rs_d       = id_rs_i;
         rt_d       = id_rt_i;
         wr_reg_d   = id_reg_dst_i ? id_rd_i : id_rt_i;
         alu_src_d  = id_alu_src_i;
         alu_ctrl_d = dec_ctrl;
         illegal_d  = dec_illegal;
         ctl_d      = '{id_reg_write_i, id_mem_read_i,
                        id_mem_write_i, id_mem_to_reg_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         wr_reg_q   <= '0;
         alu_src_q  <= 1'b0;
         alu_ctrl_q <= '0;
         illegal_q  <= 1'b0;
         ctl_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         wr_reg_q   <= wr_reg_d;
         alu_src_q  <= alu_src_d;
         alu_ctrl_q <= alu_ctrl_d;
         illegal_q  <= illegal_d;
         ctl_q      <= ctl_d;
      end
   end

`ifdef ID_EX_FORWARD_EN
   // MEM is the younger result, so it wins over WB
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [REG_AW-1:0] idx,
      input logic [DATA_W-1:0] rf
   );
      if (mem_reg_write_i && mem_wr_reg_i != '0 && mem_wr_reg_i == idx)
         return mem_result_i;
      if (wb_reg_write_i && wb_wr_reg_i != '0 && wb_wr_reg_i == idx)
         return wb_result_i;
      return rf;
   endfunction

   assign fwd_rs = fwd_sel(rs_q, rs_data_q);
   assign fwd_rt = fwd_sel(rt_q, rt_data_q);
`else
   logic unused_fwd;
   assign unused_fwd = ^{mem_reg_write_i, mem_wr_reg_i, mem_result_i,
                         wb_reg_write_i, wb_wr_reg_i, wb_result_i,
                         rs_q, rt_q};
   assign fwd_rs = rs_data_q;
   assign fwd_rt = rt_data_q;
`endif

   assign ex_valid_o       = valid_q;
   assign ex_a_o           = fwd_rs;
   assign ex_b_o           = alu_src_q ? imm_q : fwd_rt;
   assign ex_alu_control_o = alu_ctrl_q;
   assign ex_store_data_o  = fwd_rt;
   assign ex_wr_reg_o      = wr_reg_q;
   assign ex_reg_write_o   = ctl_q.reg_write;
   assign ex_mem_read_o    = ctl_q.mem_read;
   assign ex_mem_write_o   = ctl_q.mem_write;
   assign ex_mem_to_reg_o  = ctl_q.mem_to_reg;
   assign ex_illegal_o     = illegal_q;

   assign hazard_o = valid_q & ctl_q.mem_read & (wr_reg_q != '0)
                   & ((wr_reg_q == id_rs_i) | (wr_reg_q == id_rt_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
// Honours ID_EX_FORWARD_EN for the forwarding expectations.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic        v;
      logic [31:0] a, b;
      logic [3:0]  ctrl;
      logic [31:0] st;
      logic [4:0]  wr;
      logic        rw, mr, mw, m2r, ill;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic stall_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
   logic [31:0] id_rs_data_i = '0, id_rt_data_i = '0, id_imm_i = '0;
   logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
   logic [1:0]  id_alu_op_i = '0;
   logic [5:0]  id_funct_i = '0;
   logic id_alu_src_i = 0, id_reg_dst_i = 0, id_reg_write_i = 0;
   logic id_mem_read_i = 0, id_mem_write_i = 0, id_mem_to_reg_i = 0;
   logic mem_reg_write_i = 0, wb_reg_write_i = 0;
   logic [4:0]  mem_wr_reg_i = '0, wb_wr_reg_i = '0;
   logic [31:0] mem_result_i = '0, wb_result_i = '0;
   logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o;
   logic        ex_mem_write_o, ex_mem_to_reg_o, ex_illegal_o, hazard_o;
   logic [31:0] ex_a_o, ex_b_o, ex_store_data_o;
   logic [3:0]  ex_alu_control_o;
   logic [4:0]  ex_wr_reg_o;

   int checks = 0, passed = 0;
   exp_t sbq[$];
   exp_t last, zero;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i),
      .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .id_alu_op_i(id_alu_op_i), .id_funct_i(id_funct_i),
      .id_alu_src_i(id_alu_src_i), .id_reg_dst_i(id_reg_dst_i),
      .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
      .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
      .mem_reg_write_i(mem_reg_write_i), .mem_wr_reg_i(mem_wr_reg_i),
      .mem_result_i(mem_result_i), .wb_reg_write_i(wb_reg_write_i),
      .wb_wr_reg_i(wb_wr_reg_i), .wb_result_i(wb_result_i),
      .ex_valid_o(ex_valid_o), .ex_a_o(ex_a_o), .ex_b_o(ex_b_o),
      .ex_alu_control_o(ex_alu_control_o),
      .ex_store_data_o(ex_store_data_o), .ex_wr_reg_o(ex_wr_reg_o),
      .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
      .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
      .ex_illegal_o(ex_illegal_o), .hazard_o(hazard_o)
   );

   function automatic exp_t mk(
      input logic v, input logic [31:0] a, b, input logic [3:0] ctrl,
      input logic [31:0] st, input logic [4:0] wr,
      input logic [3:0] c, input logic ill
   );
      exp_t e;
      e.v = v; e.a = a; e.b = b; e.ctrl = ctrl; e.st = st; e.wr = wr;
      {e.rw, e.mr, e.mw, e.m2r} = c;
      e.ill = ill;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".valid"}, 32'(ex_valid_o), 32'(e.v));
      chk({tag, ".a"}, ex_a_o, e.a);
      chk({tag, ".b"}, ex_b_o, e.b);
      chk({tag, ".ctrl"}, 32'(ex_alu_control_o), 32'(e.ctrl));
      chk({tag, ".store"}, ex_store_data_o, e.st);
      chk({tag, ".wr_reg"}, 32'(ex_wr_reg_o), 32'(e.wr));
      chk({tag, ".ctl"},
          32'({ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o}),
          32'({e.rw, e.mr, e.mw, e.m2r}));
      chk({tag, ".illegal"}, 32'(ex_illegal_o), 32'(e.ill));
   endtask

   task automatic push(input exp_t e);
      sbq.push_back(e);
      last = e;
   endtask

   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         checks++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = sbq.pop_front();
         check_all(tag, e);
      end
   endtask

   task automatic drive(
      input logic v, input logic [31:0] rsd, rtd, imm,
      input logic [4:0] rs, rt, rd, input logic [1:0] op,
      input logic [5:0] fn, input logic src, dst, input logic [3:0] c
   );
      id_valid_i = v; id_rs_data_i = rsd; id_rt_data_i = rtd;
      id_imm_i = imm; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
      id_alu_op_i = op; id_funct_i = fn; id_alu_src_i = src;
      id_reg_dst_i = dst;
      {id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i} = c;
   endtask

   typedef struct {
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] ctrl;
      logic       ill;
   } dec_t;

   dec_t dtab[10] = '{
      '{2'b00, 6'b100010, 4'b0010, 1'b0},
      '{2'b01, 6'b100100, 4'b0110, 1'b0},
      '{2'b11, 6'b100000, 4'b0001, 1'b0},
      '{2'b10, 6'b100000, 4'b0010, 1'b0},
      '{2'b10, 6'b100010, 4'b0110, 1'b0},
      '{2'b10, 6'b100100, 4'b0000, 1'b0},
      '{2'b10, 6'b100101, 4'b0001, 1'b0},
      '{2'b10, 6'b101010, 4'b0111, 1'b0},
      '{2'b10, 6'b111111, 4'b0010, 1'b1},
      '{2'b10, 6'b000000, 4'b0010, 1'b1}
   };

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fa;
      zero = mk(0, 0, 0, 0, 0, 0, 4'b0000, 0);
      drive(1, 32'hDEAD, 32'hBEEF, 32'h1, 5'd9, 5'd9, 5'd9, 2'b10,
            6'b100000, 0, 1, 4'b1101);
      #12;
      check_all("reset", zero);
      chk("reset.hazard", 32'(hazard_o), 0);
      rst_n = 1'b1;

      drive(1, 32'd5, 32'd3, 32'h10, 5'd1, 5'd2, 5'd7, 2'b10,
            6'b100010, 0, 1, 4'b1000);
      push(mk(1, 5, 3, 4'b0110, 3, 7, 4'b1000, 0));
      tick("rsub");

      drive(1, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd1, 5'd8, 5'd12,
            2'b00, 6'b111111, 1, 0, 4'b1000);
      push(mk(1, 32'h100, 32'hFFFF_FFFC, 4'b0010, 32'h55, 8,
              4'b1000, 0));
      tick("addi");

      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h1000 + i, 32'h2000 + i, 0, 5'd1, 5'd2, 5'd3,
               dtab[i].op, dtab[i].fn, 0, 1, 4'b1000);
         push(mk(1, 32'h1000 + i, 32'h2000 + i, dtab[i].ctrl,
                 32'h2000 + i, 3, 4'b1000, dtab[i].ill));
         tick($sformatf("dec%0d", i));
      end

      drive(1, 32'h40, 32'hCAFE, 32'h8, 5'd3, 5'd4, 5'd6, 2'b00,
            6'b0, 1, 0, 4'b0010);
      push(mk(1, 32'h40, 32'h8, 4'b0010, 32'hCAFE, 4, 4'b0010, 0));
      tick("sw");

      stall_i = 1'b1;
      drive(1, 32'h77, 32'h88, 32'h99, 5'd10, 5'd11, 5'd12, 2'b10,
            6'b101010, 0, 1, 4'b1101);
      for (int i = 0; i < 3; i++) begin
         push(last);
         tick($sformatf("stall%0d", i));
      end
      flush_i = 1'b1;
      push(zero);
      tick("stall_flush");
      stall_i = 1'b0;
      flush_i = 1'b0;

      push(mk(1, 32'h77, 32'h88, 4'b0111, 32'h88, 12, 4'b1101, 0));
      tick("after_stall");
      flush_i = 1'b1;
      push(zero);
      tick("flush");
      flush_i = 1'b0;
      drive(0, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 2'b11,
            6'b0, 1, 1, 4'b1111);
      push(zero);
      tick("idle_bubble");

      drive(1, 32'h200, 32'h0, 32'h4, 5'd2, 5'd9, 5'd0, 2'b00,
            6'b0, 1, 0, 4'b1101);
      push(mk(1, 32'h200, 32'h4, 4'b0010, 0, 9, 4'b1101, 0));
      tick("lw");
      id_rs_i = 5'd9; id_rt_i = 5'd1; #1;
      chk("hazard.rs", 32'(hazard_o), 1);
      id_rs_i = 5'd1; id_rt_i = 5'd9; #1;
      chk("hazard.rt", 32'(hazard_o), 1);
      id_rs_i = 5'd1; id_rt_i = 5'd2; #1;
      chk("hazard.nomatch", 32'(hazard_o), 0);

      drive(1, 32'h200, 32'h0, 32'h4, 5'd2, 5'd0, 5'd0, 2'b00,
            6'b0, 1, 0, 4'b1101);
      push(mk(1, 32'h200, 32'h4, 4'b0010, 0, 0, 4'b1101, 0));
      tick("lw_r0");
      id_rs_i = 5'd0; #1;
      chk("hazard.r0", 32'(hazard_o), 0);

      drive(1, 32'h1, 32'h2, 32'h0, 5'd3, 5'd4, 5'd9, 2'b10,
            6'b100000, 0, 1, 4'b1000);
      push(mk(1, 1, 2, 4'b0010, 2, 9, 4'b1000, 0));
      tick("add_r9");
      id_rs_i = 5'd9; #1;
      chk("hazard.noload", 32'(hazard_o), 0);

      drive(1, 32'h300, 32'h301, 32'h0, 5'd2, 5'd9, 5'd9, 2'b00,
            6'b0, 1, 0, 4'b1101);
      push(mk(1, 32'h300, 32'h0, 4'b0010, 32'h301, 9, 4'b1101, 0));
      tick("lw_pre_rst");
      stall_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst_mid", zero);
      chk("rst_mid.hazard", 32'(hazard_o), 0);
      #2;
      rst_n = 1'b1;
      push(zero);
      tick("rst_stall_hold");
      stall_i = 1'b0;

      mem_reg_write_i = 1; mem_wr_reg_i = 5'd4; mem_result_i = 32'h11;
      wb_reg_write_i = 1; wb_wr_reg_i = 5'd4; wb_result_i = 32'h22;
      drive(1, 32'hAA, 32'hBB, 32'h0, 5'd4, 5'd6, 5'd5, 2'b10,
            6'b100101, 0, 1, 4'b1000);
      fa = FWD ? 32'h11 : 32'hAA;
      push(mk(1, fa, 32'hBB, 4'b0001, 32'hBB, 5, 4'b1000, 0));
      tick("fwd_mem");
      mem_reg_write_i = 0; #1;
      fa = FWD ? 32'h22 : 32'hAA;
      check_all("fwd_wb", mk(1, fa, 32'hBB, 4'b0001, 32'hBB, 5,
                             4'b1000, 0));
      mem_reg_write_i = 1; mem_wr_reg_i = 5'd0; #1;
      check_all("fwd_r0", mk(1, fa, 32'hBB, 4'b0001, 32'hBB, 5,
                             4'b1000, 0));
      mem_wr_reg_i = 5'd4; wb_wr_reg_i = 5'd6; #1;
      fa = FWD ? 32'h11 : 32'hAA;
      check_all("fwd_split", mk(1, fa, FWD ? 32'h22 : 32'hBB, 4'b0001,
                                FWD ? 32'h22 : 32'hBB, 5, 4'b1000, 0));
      mem_reg_write_i = 0; wb_reg_write_i = 0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
